// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the MIPS fetch/decode boundary.
//   - fetch_state_t : fetch FSM states (RUN, WAIT_DISCARD)
//   - DEF_NOP_INST  : bubble instruction (sll $0,$0,0)
//   - DEF_RESET_PC  : default PC after reset
//   - if_id_t       : IF/ID pipeline register contents, reusable by decode
package pipeline_pkg;

  typedef enum logic [0:0] {
    RUN          = 1'b0,
    WAIT_DISCARD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage and memory.
//   imem_addr  : fetch address (driven by fetch)
//   imem_rdata : instruction word, valid when imem_ready=1 (driven by memory)
//   imem_ready : memory returns imem_rdata for imem_addr this cycle
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with write enable and synchronous flush-to-NOP.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   i_we           : 0 freezes the register (takes priority over flush)
//   i_flush        : 1 loads the bubble {0, NOP_INST} instead of i_d
//   i_d            : next IF/ID contents
//   o_q            : registered IF/ID contents
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   i_we,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q.pc_plus_4 <= 32'h0;
      r_q.inst      <= NOP_INST;
    end else if (i_we) begin
      if (i_flush) begin
        r_q.pc_plus_4 <= 32'h0;
        r_q.inst      <= NOP_INST;
      end else begin
        r_q <= i_d;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, issues instruction
// fetches and produces the IF/ID pair consumed by decode.
// Optional feature macro: FETCH_DELAY_SLOT_EN (MIPS branch delay slot;
// the fetch following a taken branch is kept instead of flushed).
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   imem             : instruction-memory bus (master modport)
//   BranchAddr       : branch target from ID
//   brunch_taken     : ID compare equal
//   brunch_control   : ID instruction is a branch
//   PCWrite          : 0 holds PC (load-use stall)
//   IFIDWrite        : 0 holds the IF/ID register
//   IDpc_plus_4      : registered PC+4 of the instruction in ID
//   IDinst           : registered instruction in ID
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic                clock,
  input  logic                reset_n,
  fetch_stage_if.master       imem,
  input  logic [31:0]         BranchAddr,
  input  logic                brunch_taken,
  input  logic                brunch_control,
  input  logic                PCWrite,
  input  logic                IFIDWrite,
  output logic [31:0]         IDpc_plus_4,
  output logic [31:0]         IDinst
);

  fetch_state_t r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_redirect_q, w_redirect_q_next;
  logic [31:0]  w_pc_plus_4;
  logic         w_redirect;
  logic         w_ifid_flush;
  if_id_t       w_ifid_d;
  if_id_t       w_ifid_q;

  // Branch operands are stale during a load-use stall, so a stall
  // suppresses the redirect.
  assign w_redirect  = brunch_control & brunch_taken & PCWrite;
  assign w_pc_plus_4 = r_pc + 32'd4;

  assign w_ifid_d.pc_plus_4 = w_pc_plus_4;
  assign w_ifid_d.inst      = imem.imem_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_redirect_q <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_redirect_q <= w_redirect_q_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_redirect_q_next = r_redirect_q;
    w_ifid_flush      = 1'b1;
    case (r_state)
      RUN: begin
        if (!PCWrite) begin
          w_ifid_flush = 1'b1;
        end else if (!imem.imem_ready) begin
          // The request is outstanding: the address must stay stable, so a
          // redirect is parked until the in-flight word returns.
          if (w_redirect) begin
            w_redirect_q_next = BranchAddr;
            w_state_next      = WAIT_DISCARD;
          end
          w_ifid_flush = 1'b1;
        end else if (w_redirect) begin
          w_pc_next = BranchAddr;
`ifdef FETCH_DELAY_SLOT_EN
          w_ifid_flush = 1'b0;
`else
          w_ifid_flush = 1'b1;
`endif
        end else begin
          w_pc_next    = w_pc_plus_4;
          w_ifid_flush = 1'b0;
        end
      end
      WAIT_DISCARD: begin
        // ID holds a bubble here, so any redirect request is ignored.
        if (imem.imem_ready) begin
          w_pc_next    = r_redirect_q;
          w_state_next = RUN;
`ifdef FETCH_DELAY_SLOT_EN
          w_ifid_flush = 1'b0;
`else
          w_ifid_flush = 1'b1;
`endif
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .i_we    (IFIDWrite),
    .i_flush (w_ifid_flush),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem.imem_addr = r_pc;
  assign IDpc_plus_4    = w_ifid_q.pc_plus_4;
  assign IDinst         = w_ifid_q.inst;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic [31:0] BranchAddr;
  logic        brunch_taken;
  logic        brunch_control;
  logic        PCWrite;
  logic        IFIDWrite;
  logic [31:0] IDpc_plus_4;
  logic [31:0] IDinst;
  int          total;
  int          bad;

  fetch_stage_if imem ();

  // Memory model: word at address A holds A>>2.
  assign imem.imem_rdata = imem.imem_addr >> 2;

  fetch_stage dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem           (imem.master),
    .BranchAddr     (BranchAddr),
    .brunch_taken   (brunch_taken),
    .brunch_control (brunch_control),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDpc_plus_4    (IDpc_plus_4),
    .IDinst         (IDinst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] a, input logic [31:0] i,
                      input logic [31:0] p);
    chk({tag, ".addr"}, imem.imem_addr, a);
    chk({tag, ".inst"}, IDinst, i);
    chk({tag, ".pc4"}, IDpc_plus_4, p);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic branch(input logic on, input logic [31:0] tgt);
    brunch_control = on;
    brunch_taken   = on;
    BranchAddr     = tgt;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n         = 1'b0;
    imem.imem_ready = 1'b1;
    PCWrite         = 1'b1;
    IFIDWrite       = 1'b1;
    branch(1'b0, 32'h0);
    #2;
    chk3("reset", 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("release.addr", imem.imem_addr, 32'h0);

    // Sequential fetch
    step(); chk3("seq1", 32'h4, 32'h0, 32'h4);
    step(); chk3("seq2", 32'h8, 32'h1, 32'h8);

    // Taken branch at PC=8
    branch(1'b1, 32'h40);
    step(); chk3("br", 32'h40, DS ? 32'h2 : 32'h0, DS ? 32'hC : 32'h0);
    branch(1'b0, 32'h0);
    step(); chk3("br_tgt", 32'h44, 32'h10, 32'h44);

    // Stall with a taken branch pending
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    branch(1'b1, 32'h100);
    step(); chk3("stall1", 32'h44, 32'h10, 32'h44);
    step(); chk3("stall2", 32'h44, 32'h10, 32'h44);
    PCWrite = 1'b1; IFIDWrite = 1'b1;
    branch(1'b0, 32'h0);
    step(); chk3("resume", 32'h48, 32'h11, 32'h48);

    // Memory wait states at PC=0x10
    branch(1'b1, 32'h10);
    step(); chk3("to10", 32'h10, DS ? 32'h12 : 32'h0, DS ? 32'h4C : 32'h0);
    branch(1'b0, 32'h0);
    imem.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk3("wait", 32'h10, 32'h0, 32'h0);
    end
    imem.imem_ready = 1'b1;
    step(); chk3("wait_done", 32'h14, 32'h4, 32'h14);

    // Redirect during an outstanding fetch at PC=0x20
    branch(1'b1, 32'h20);
    step(); chk("to20.addr", imem.imem_addr, 32'h20);
    imem.imem_ready = 1'b0;
    branch(1'b1, 32'h80);
    step(); chk3("wd1", 32'h20, 32'h0, 32'h0);
    branch(1'b1, 32'h200);
    step(); chk3("wd2", 32'h20, 32'h0, 32'h0);
    imem.imem_ready = 1'b1;
    step(); chk3("wd_ret", 32'h80, DS ? 32'h8 : 32'h0, DS ? 32'h24 : 32'h0);
    branch(1'b0, 32'h0);
    step(); chk3("at80", 32'h84, 32'h20, 32'h84);

    // Async reset while in WAIT_DISCARD, IF/ID frozen with live content
    imem.imem_ready = 1'b0;
    IFIDWrite = 1'b0;
    branch(1'b1, 32'h300);
    step(); chk3("pre_rst", 32'h84, 32'h20, 32'h84);
    branch(1'b0, 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    chk3("async_rst", 32'h0, 32'h0, 32'h0);
    #1;
    reset_n = 1'b1;
    imem.imem_ready = 1'b1;
    IFIDWrite = 1'b1;
    step(); chk3("post_rst", 32'h4, 32'h0, 32'h4);

    // PC wrap-around
    branch(1'b1, 32'hFFFF_FFFC);
    step(); chk3("to_top", 32'hFFFF_FFFC, DS ? 32'h1 : 32'h0, DS ? 32'h8 : 32'h0);
    branch(1'b0, 32'h0);
    step(); chk3("wrap", 32'h0, 32'h3FFF_FFFF, 32'h0);
    step(); chk3("after_wrap", 32'h4, 32'h0, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
